// File: rtl/control_command_sender_if.sv
// Host-side bundle for control_command_sender: control command handshake plus
// status word reception controls and results.
interface control_command_sender_if #(
    parameter int CONTROL_SIZE = 40,
    parameter int WORD_SIZE    = 32,
    parameter int SIZE_WORD    = 3
);
    logic [CONTROL_SIZE-1:0] cmd_value;
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [SIZE_WORD-1:0]    status_bytes;
    logic [15:0]             frame_timeout;
    logic [WORD_SIZE-1:0]    status_word;
    logic                    status_valid;
    logic                    status_timeout_err;

    modport master (
        output cmd_value, cmd_valid, status_bytes, frame_timeout,
        input  cmd_ready, status_word, status_valid, status_timeout_err
    );

    modport slave (
        input  cmd_value, cmd_valid, status_bytes, frame_timeout,
        output cmd_ready, status_word, status_valid, status_timeout_err
    );
endinterface

// File: rtl/control_command_sender.sv
// Ground-side status/control link: frames 40-bit control values as nibble
// characters over UART and reassembles LSB-first status words from received bytes.
module control_command_sender #(
    parameter int WORD_SIZE    = 32,
    parameter int CONTROL_SIZE = 40,
    parameter int SIZE_WORD    = 3,
    parameter int DATA_WIDTH   = 8,
    parameter int SYMBOL_WIDTH = 4,
    parameter logic [DATA_WIDTH-1:0] SYMBOL_PREFIX    = 8'h30,
    parameter logic [DATA_WIDTH-1:0] ESCAPE_CHARACTER = 8'h0D,
    parameter logic [DATA_WIDTH-1:0] CLEAN_CHARACTER  = 8'h20
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [15:0]               prescale,
    control_command_sender_if.slave   bus,
    output logic [3:0]                uart_status,
    input  logic                      rxd,
    output logic                      txd
);
    localparam int NIBBLES = CONTROL_SIZE / SYMBOL_WIDTH;
    localparam int CW      = $clog2(NIBBLES + 1);

    typedef enum logic [1:0] {IDLE, CLEAN, NIBBLE, TERM} tx_state_t;

    tx_state_t               state;
    logic [CONTROL_SIZE-1:0] shreg;
    logic [CW-1:0]           nib_cnt;
    logic [DATA_WIDTH-1:0]   tx_data;
    logic                    tx_valid;
    logic                    tx_ready;
    logic                    cmd_ready_r;

    logic [DATA_WIDTH-1:0]   rx_data;
    logic                    rx_valid;
    logic                    rx_busy, tx_busy, rx_overrun_error, rx_frame_error;

    logic [WORD_SIZE-1:0]    acc;
    logic [WORD_SIZE-1:0]    acc_next;
    logic [SIZE_WORD-1:0]    idx;
    logic [SIZE_WORD-1:0]    eff_bytes;
    logic [15:0]             gap;
    logic [WORD_SIZE-1:0]    status_word_r;
    logic                    status_valid_r;
    logic                    status_timeout_err_r;

    uart #(.DATA_WIDTH(DATA_WIDTH)) u_uart (
        .clk              (clk),
        .rst              (rst),
        .s_axis_tdata     (tx_data),
        .s_axis_tvalid    (tx_valid),
        .s_axis_tready    (tx_ready),
        .m_axis_tdata     (rx_data),
        .m_axis_tvalid    (rx_valid),
        .m_axis_tready    (1'b1),
        .rxd              (rxd),
        .txd              (txd),
        .tx_busy          (tx_busy),
        .rx_busy          (rx_busy),
        .rx_overrun_error (rx_overrun_error),
        .rx_frame_error   (rx_frame_error),
        .prescale         (prescale)
    );

    assign uart_status            = {rx_frame_error, rx_overrun_error, rx_busy, tx_busy};
    assign bus.cmd_ready          = cmd_ready_r;
    assign bus.status_word        = status_word_r;
    assign bus.status_valid       = status_valid_r;
    assign bus.status_timeout_err = status_timeout_err_r;

    // Each character is held on the UART input until accepted; the state moves on the handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            shreg       <= '0;
            nib_cnt     <= '0;
            tx_data     <= '0;
            tx_valid    <= 1'b0;
            cmd_ready_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cmd_valid && cmd_ready_r) begin
                        shreg       <= bus.cmd_value;
                        nib_cnt     <= CW'(NIBBLES);
                        tx_data     <= CLEAN_CHARACTER;
                        tx_valid    <= 1'b1;
                        cmd_ready_r <= 1'b0;
                        state       <= CLEAN;
                    end else begin
                        cmd_ready_r <= 1'b1;
                    end
                end
                CLEAN, NIBBLE: begin
                    if (tx_ready) begin
                        if (nib_cnt != '0) begin
                            tx_data <= SYMBOL_PREFIX |
                                       DATA_WIDTH'(shreg[CONTROL_SIZE-1 -: SYMBOL_WIDTH]);
                            shreg   <= shreg << SYMBOL_WIDTH;
                            nib_cnt <= nib_cnt - 1'b1;
                            state   <= NIBBLE;
                        end else begin
                            tx_data <= ESCAPE_CHARACTER;
                            state   <= TERM;
                        end
                    end
                end
                TERM: begin
                    if (tx_ready) begin
                        tx_valid    <= 1'b0;
                        cmd_ready_r <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        eff_bytes = (bus.status_bytes > SIZE_WORD'(4)) ? SIZE_WORD'(4) : bus.status_bytes;
        acc_next  = acc | (WORD_SIZE'(rx_data) << {idx, 3'b000});
    end

    // A byte landing on the timeout cycle takes priority over the timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc                  <= '0;
            idx                  <= '0;
            gap                  <= '0;
            status_word_r        <= '0;
            status_valid_r       <= 1'b0;
            status_timeout_err_r <= 1'b0;
        end else begin
            status_valid_r       <= 1'b0;
            status_timeout_err_r <= 1'b0;
            if (rx_valid) begin
                gap <= '0;
                if (eff_bytes != '0) begin
                    if ((idx + 1'b1) >= eff_bytes) begin
                        status_word_r  <= acc_next;
                        status_valid_r <= 1'b1;
                        acc            <= '0;
                        idx            <= '0;
                    end else begin
                        acc <= acc_next;
                        idx <= idx + 1'b1;
                    end
                end
            end else if (idx != '0) begin
                if (bus.frame_timeout != 16'd0 && gap == bus.frame_timeout) begin
                    acc                  <= '0;
                    idx                  <= '0;
                    gap                  <= '0;
                    status_timeout_err_r <= 1'b1;
                end else begin
                    gap <= gap + 16'd1;
                end
            end
        end
    end
endmodule

// 8N1 UART; one bit lasts prescale*8 clock cycles. Receiver samples mid-bit.
module uart #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    input  logic                  rxd,
    output logic                  txd,
    output logic                  tx_busy,
    output logic                  rx_busy,
    output logic                  rx_overrun_error,
    output logic                  rx_frame_error,
    input  logic [15:0]           prescale
);
    logic [18:0]           bit_period, half_period;
    logic [DATA_WIDTH:0]   tx_shreg;
    logic [18:0]           tx_cnt;
    logic [3:0]            tx_bits;
    logic                  rxd_s1, rxd_s2;
    logic [18:0]           rx_cnt;
    logic [3:0]            rx_bits;
    logic [DATA_WIDTH-1:0] rx_shreg;

    assign bit_period    = {prescale, 3'b000};
    assign half_period   = {1'b0, prescale, 2'b00};
    assign s_axis_tready = !tx_busy;

    // Start bit goes out on load; the shifter then emits data LSB first and the stop bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            txd      <= 1'b1;
            tx_busy  <= 1'b0;
            tx_shreg <= '0;
            tx_cnt   <= '0;
            tx_bits  <= '0;
        end else if (!tx_busy) begin
            if (s_axis_tvalid) begin
                tx_busy  <= 1'b1;
                txd      <= 1'b0;
                tx_shreg <= {1'b1, s_axis_tdata};
                tx_cnt   <= bit_period - 19'd1;
                tx_bits  <= 4'(DATA_WIDTH + 1);
            end
        end else if (tx_cnt != '0) begin
            tx_cnt <= tx_cnt - 19'd1;
        end else if (tx_bits != '0) begin
            txd      <= tx_shreg[0];
            tx_shreg <= tx_shreg >> 1;
            tx_bits  <= tx_bits - 4'd1;
            tx_cnt   <= bit_period - 19'd1;
        end else begin
            tx_busy <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxd_s1           <= 1'b1;
            rxd_s2           <= 1'b1;
            rx_busy          <= 1'b0;
            rx_cnt           <= '0;
            rx_bits          <= '0;
            rx_shreg         <= '0;
            m_axis_tdata     <= '0;
            m_axis_tvalid    <= 1'b0;
            rx_overrun_error <= 1'b0;
            rx_frame_error   <= 1'b0;
        end else begin
            rxd_s1           <= rxd;
            rxd_s2           <= rxd_s1;
            rx_overrun_error <= 1'b0;
            rx_frame_error   <= 1'b0;
            if (m_axis_tvalid && m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
            if (!rx_busy) begin
                if (!rxd_s2) begin
                    rx_busy <= 1'b1;
                    rx_cnt  <= half_period - 19'd1;
                    rx_bits <= 4'(DATA_WIDTH + 2);
                end
            end else if (rx_cnt != '0) begin
                rx_cnt <= rx_cnt - 19'd1;
            end else if (rx_bits == 4'(DATA_WIDTH + 2)) begin
                if (rxd_s2) begin
                    rx_busy <= 1'b0;
                end else begin
                    rx_bits <= rx_bits - 4'd1;
                    rx_cnt  <= bit_period - 19'd1;
                end
            end else if (rx_bits > 4'd1) begin
                rx_shreg <= {rxd_s2, rx_shreg[DATA_WIDTH-1:1]};
                rx_bits  <= rx_bits - 4'd1;
                rx_cnt   <= bit_period - 19'd1;
            end else begin
                rx_busy <= 1'b0;
                if (rxd_s2) begin
                    m_axis_tdata     <= rx_shreg;
                    m_axis_tvalid    <= 1'b1;
                    rx_overrun_error <= m_axis_tvalid && !m_axis_tready;
                end else begin
                    rx_frame_error <= 1'b1;
                end
            end
        end
    end
endmodule

// File: doc/control_command_sender.md
# control_command_sender

Ground-side counterpart of the on-board status/control UART link. Serialises 40-bit control values into the nibble-character framing the on-board controller decodes, and reassembles the LSB-first status words it transmits. Instantiates the shared `uart` core and sits between the host/test logic and the physical `txd`/`rxd` pair.

## Interface

**Parameters**

- `WORD_SIZE`, 32: status word width.
- `CONTROL_SIZE`, 40: control value width; must be a multiple of `SYMBOL_WIDTH`.
- `SIZE_WORD`, 3: width of `status_bytes`.
- `DATA_WIDTH`, 8: UART character width.
- `SYMBOL_WIDTH`, 4: payload bits per control character.
- `SYMBOL_PREFIX`, 8'h30: OR-ed above each nibble.
- `ESCAPE_CHARACTER`, 8'h0D: control frame terminator.
- `CLEAN_CHARACTER`, 8'h20: control frame opener; flushes the far-end shift register.

**Ports**

- `clk` input 1: clock.
- `rst` input 1: reset, asynchronous, active-high.
- `prescale` input 16: passed to `uart`.
- `cmd_value` input CONTROL_SIZE: control value to send.
- `cmd_valid` input 1: request; accepted only when `cmd_ready`=1.
- `cmd_ready` output 1: transmitter idle.
- `status_bytes` input SIZE_WORD: bytes per status word; 0 disables reception; values above 4 are clamped to 4.
- `frame_timeout` input 16: maximum idle cycles inside a partial status word; 0 disables the timeout.
- `status_word` output WORD_SIZE: last assembled word.
- `status_valid` output 1: one-cycle pulse, word complete.
- `status_timeout_err` output 1: one-cycle pulse, partial word discarded.
- `uart_status` output 4: {rx_frame_error, rx_overrun_error, rx_busy, tx_busy} from `uart`.
- `rxd` input 1, `txd` output 1: serial lines.

## Operation

**TX FSM**, states IDLE, CLEAN, NIBBLE, TERM.
- IDLE: `cmd_ready`=1. On `cmd_valid`, latch `cmd_value` into shift register, nibble counter = CONTROL_SIZE/SYMBOL_WIDTH (10), go to CLEAN, drop `cmd_ready`.
- CLEAN: present 0x20. NIBBLE: present `SYMBOL_PREFIX | shreg[MSB -: 4]`, shift left 4, decrement counter; leave after the counter reaches 0. TERM: present 0x0D, then return to IDLE.
- Each character: `s_axis_tvalid` is raised with its data and held, data stable, until the cycle `s_axis_tready`=1. The state advances on that cycle.
- Characters are always 0x30–0x3F, so they never collide with 0x0D or 0x20.
- `cmd_valid` while busy is ignored; no queueing.

**RX path.** `m_axis_tready` is tied to 1.
- Each byte received when `status_bytes`≠0: `acc |= byte << (8*idx)`, `idx++`.
- When `idx` reaches the clamped `status_bytes`:
  - `status_word` ← the completed accumulator, upper bytes zero.
  - `status_valid` pulses.
  - `acc` and `idx` clear.
- When `status_bytes`=0, bytes are dropped and `acc`/`idx` stay 0.
- Timeout: a gap counter clears on every byte and increments while `idx`≠0. When it equals `frame_timeout` (≠0), `acc`, `idx` and the counter clear and `status_timeout_err` pulses.
- A byte arriving in the same cycle as a timeout wins: it is accumulated and no error is raised.
- A `status_bytes` change takes effect at the next byte.

## Timing

- **Reset values:** `cmd_ready`=0 (goes 1 on the first clk after release), `status_word`=0, `status_valid`=0, `status_timeout_err`=0, `s_axis_tvalid`=0, TX FSM in IDLE, `acc`/`idx`/gap counter 0. `txd` idles high via `uart`.
- **Reset mid-frame:** abandons the character in flight and the partial word; nothing is emitted afterwards.
- **Command latency:** `cmd_valid` sampled at edge N, `s_axis_tvalid`=1 with 0x20 after edge N.
- **Frame length:** 12 characters per command. `cmd_ready` returns the cycle after TERM's handshake.
- **Status latency:** `status_valid` asserts the cycle after the `m_axis_tvalid` of the final byte; `status_word` is registered with it and held until the next word.
- **Outputs:** all registered except `uart_status`.

## Test plan

- **Command frame:** `cmd_value`=40'h123456789A -> `txd` decodes to 0x20,0x31,0x32,0x33,0x34,0x35,0x36,0x37,0x38,0x39,0x3A,0x0D. `cmd_ready` is low throughout and high after.
- **Busy / back-to-back:** a second `cmd_valid` with 40'hFFFFFFFFFF during the first frame is ignored. Re-issued after `cmd_ready` -> 0x20, ten 0x3F, 0x0D.
- **Status assembly:** `status_bytes`=2, rx 0xAB,0xCD -> `status_word`=32'h0000CDAB with a 1-cycle `status_valid`. `status_bytes`=7, rx 0x01..0x04 -> 32'h04030201.
- **Timeout:** `status_bytes`=4, `frame_timeout`=100, rx 0x11 then silence -> `status_timeout_err` pulse, no `status_valid`. Then 0xAA,0xBB,0xCC,0xDD -> 32'hDDCCBBAA.
- **Disabled reception:** `status_bytes`=0, rx 3 bytes -> no pulses, `status_word` unchanged.
- **Reset mid-operation:** `rst` during the 5th character and during a partial status word -> outputs at reset values. A fresh command afterwards is sent complete and correct.
